// File: rtl/lmac_tx_pkt_arbiter_if.sv
// Requester FIFO and LMAC TX FIFO signal bundle for lmac_tx_pkt_arbiter.
// master = arbiter side, slave = FIFO/LMAC side.
interface lmac_tx_pkt_arbiter_if;
  logic        r0_cnt_empty;
  logic        r0_cnt_rden;
  logic [15:0] r0_cnt_data;
  logic        r0_dat_empty;
  logic        r0_dat_rden;
  logic [63:0] r0_dat_data;
  logic        r1_cnt_empty;
  logic        r1_cnt_rden;
  logic [15:0] r1_cnt_data;
  logic        r1_dat_empty;
  logic        r1_dat_rden;
  logic [63:0] r1_dat_data;
  logic        tx_mac_wr;
  logic [63:0] tx_mac_data;
  logic [12:0] tx_mac_usedw;
  logic        tx_mac_full;

  modport master (
    input  r0_cnt_empty, r0_cnt_data,
    input  r0_dat_empty, r0_dat_data,
    input  r1_cnt_empty, r1_cnt_data,
    input  r1_dat_empty, r1_dat_data,
    input  tx_mac_usedw, tx_mac_full,
    output r0_cnt_rden, r0_dat_rden,
    output r1_cnt_rden, r1_dat_rden,
    output tx_mac_wr, tx_mac_data
  );

  modport slave (
    output r0_cnt_empty, r0_cnt_data,
    output r0_dat_empty, r0_dat_data,
    output r1_cnt_empty, r1_cnt_data,
    output r1_dat_empty, r1_dat_data,
    output tx_mac_usedw, tx_mac_full,
    input  r0_cnt_rden, r0_dat_rden,
    input  r1_cnt_rden, r1_dat_rden,
    input  tx_mac_wr, tx_mac_data
  );
endinterface

// File: rtl/lmac_tx_pkt_arbiter.sv
// Packet-granular 2-requester arbiter into the LMAC TX FIFO.
// Define ARB_STRICT_PRI_EN for fixed r0 priority instead of round-robin.
module lmac_tx_pkt_arbiter #(
  parameter int FIFO_DEPTH = 8192,
  parameter int MARGIN     = 4,
  parameter int MAX_BCNT   = 1518
) (
  input  logic                 clk,
  input  logic                 reset_,
  lmac_tx_pkt_arbiter_if.master bus,
  output logic [1:0]           grant,
  output logic                 drop_pulse,
  output logic [15:0]          pkt_cnt0,
  output logic [15:0]          pkt_cnt1
);

  localparam logic [13:0] LIMIT = 14'(FIFO_DEPTH - MARGIN);
  localparam logic [15:0] BMAX  = 16'(MAX_BCNT);

  typedef enum logic [2:0] {
    IDLE, CNT_WAIT, CHECK, HDR, DATA, DROP
  } state_t;

  state_t      state;
  logic        own;
  logic        rr;
  logic        rd_v;
  logic [7:0]  words;
  logic [7:0]  issued;
  logic [7:0]  written;

  logic [15:0] cur_cnt;
  logic [63:0] cur_dat;
  logic        cur_empty;
  logic [16:0] cnt_p7;
  logic [13:0] w14;
  logic [7:0]  words_n;
  logic [13:0] need;
  logic        bad;
  logic        space_ok;
  logic        rd_en;
  logic        req0;
  logic        req1;
  logic        win;
  logic        pkt_done;

  always_comb begin
    cur_cnt   = own ? bus.r1_cnt_data : bus.r0_cnt_data;
    cur_dat   = own ? bus.r1_dat_data : bus.r0_dat_data;
    cur_empty = own ? bus.r1_dat_empty : bus.r0_dat_empty;
    cnt_p7    = {1'b0, cur_cnt} + 17'd7;
    w14       = cnt_p7[16:3];
    words_n   = (w14 > 14'd255) ? 8'hFF : w14[7:0];
    need      = {1'b0, bus.tx_mac_usedw} + w14 + 14'd1;
    bad       = (cur_cnt == 16'd0) || (cur_cnt > BMAX);
    space_ok  = (need <= LIMIT) && !bus.tx_mac_full;
    rd_en     = !cur_empty && (issued < words) &&
                ((state == DATA && !bus.tx_mac_full) ||
                 state == DROP);
    req0      = !bus.r0_cnt_empty;
    req1      = !bus.r1_cnt_empty;
`ifdef ARB_STRICT_PRI_EN
    win       = !req0;
`else
    win       = (req0 && req1) ? rr : req1;
`endif
    pkt_done  = rd_v && (written + 8'd1 == words);
  end

  // Data reads are combinational so the empty flag gates them
  // in the same cycle; the write side is registered.
  assign bus.r0_dat_rden = rd_en & ~own;
  assign bus.r1_dat_rden = rd_en & own;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state           <= IDLE;
      own             <= 1'b0;
      rr              <= 1'b0;
      rd_v            <= 1'b0;
      words           <= '0;
      issued          <= '0;
      written         <= '0;
      grant           <= '0;
      drop_pulse      <= 1'b0;
      pkt_cnt0        <= '0;
      pkt_cnt1        <= '0;
      bus.r0_cnt_rden <= 1'b0;
      bus.r1_cnt_rden <= 1'b0;
      bus.tx_mac_wr   <= 1'b0;
      bus.tx_mac_data <= '0;
    end else begin
      bus.tx_mac_wr <= 1'b0;
      drop_pulse    <= 1'b0;
      rd_v          <= rd_en && (state == DATA);
      if (rd_en) issued <= issued + 8'd1;
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            own             <= win;
            grant           <= win ? 2'b10 : 2'b01;
            bus.r0_cnt_rden <= !win;
            bus.r1_cnt_rden <= win;
            state           <= CNT_WAIT;
          end
        end
        CNT_WAIT: begin
          bus.r0_cnt_rden <= 1'b0;
          bus.r1_cnt_rden <= 1'b0;
          issued          <= '0;
          written         <= '0;
          state           <= CHECK;
        end
        // Count FIFO output holds until the next read of it.
        CHECK: begin
          words <= words_n;
          if (bad) begin
            state <= DROP;
          end else if (space_ok) begin
            bus.tx_mac_wr   <= 1'b1;
            bus.tx_mac_data <= {48'h0, cur_cnt};
            state           <= HDR;
          end
        end
        HDR: state <= DATA;
        DATA: begin
          if (rd_v) begin
            bus.tx_mac_wr   <= 1'b1;
            bus.tx_mac_data <= cur_dat;
            written         <= written + 8'd1;
          end
          if (pkt_done) begin
            grant <= '0;
            rr    <= ~own;
            if (own) pkt_cnt1 <= pkt_cnt1 + 16'd1;
            else     pkt_cnt0 <= pkt_cnt0 + 16'd1;
            state <= IDLE;
          end
        end
        DROP: begin
          if (issued == words) begin
            drop_pulse <= 1'b1;
            grant      <= '0;
            rr         <= ~own;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lmac_tx_pkt_arbiter.sv
// Directed bench for lmac_tx_pkt_arbiter with FIFO models.
// Honours ARB_STRICT_PRI_EN for the arbitration-order checks.
module tb_lmac_tx_pkt_arbiter;

  logic        clk = 1'b0;
  logic        reset_;
  logic [1:0]  grant;
  logic        drop_pulse;
  logic [15:0] pkt_cnt0;
  logic [15:0] pkt_cnt1;

  always #5 clk = ~clk;

  lmac_tx_pkt_arbiter_if bus ();

  lmac_tx_pkt_arbiter dut (
    .clk        (clk),
    .reset_     (reset_),
    .bus        (bus),
    .grant      (grant),
    .drop_pulse (drop_pulse),
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1)
  );

  logic [15:0] cmem [2][64];
  logic [63:0] dmem [2][1024];
  int          cwp [2] = '{0, 0};
  int          crp [2] = '{0, 0};
  int          dwp [2] = '{0, 0};
  int          drp [2] = '{0, 0};
  int          uflow = 0;
  logic [15:0] cout [2] = '{16'h0, 16'h0};
  logic [63:0] dout [2] = '{64'h0, 64'h0};
  logic        crd [2];
  logic        drd [2];

  assign crd[0] = bus.r0_cnt_rden;
  assign crd[1] = bus.r1_cnt_rden;
  assign drd[0] = bus.r0_dat_rden;
  assign drd[1] = bus.r1_dat_rden;
  assign bus.r0_cnt_empty = (cwp[0] == crp[0]);
  assign bus.r1_cnt_empty = (cwp[1] == crp[1]);
  assign bus.r0_dat_empty = (dwp[0] == drp[0]);
  assign bus.r1_dat_empty = (dwp[1] == drp[1]);
  assign bus.r0_cnt_data  = cout[0];
  assign bus.r1_cnt_data  = cout[1];
  assign bus.r0_dat_data  = dout[0];
  assign bus.r1_dat_data  = dout[1];

  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (crd[n] && cwp[n] != crp[n]) begin
        cout[n] <= cmem[n][crp[n][5:0]];
        crp[n]  <= crp[n] + 1;
      end
      if (drd[n] && dwp[n] != drp[n]) begin
        dout[n] <= dmem[n][drp[n][9:0]];
        drp[n]  <= drp[n] + 1;
      end
      if ((drd[n] && dwp[n] == drp[n]) ||
          (crd[n] && cwp[n] == crp[n]))
        uflow <= uflow + 1;
    end
  end

  int          cyc = 0;
  int          drops = 0;
  logic [63:0] wlog [$];
  int          wcyc [$];
  logic [1:0]  glog [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.tx_mac_wr) begin
      wlog.push_back(bus.tx_mac_data);
      wcyc.push_back(cyc);
      glog.push_back(grant);
    end
    if (drop_pulse) drops <= drops + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_d(input int n, input logic [63:0] v);
    dmem[n][dwp[n][9:0]] = v;
    dwp[n] = dwp[n] + 1;
  endtask

  task automatic push_c(input int n, input logic [15:0] v);
    cmem[n][cwp[n][5:0]] = v;
    cwp[n] = cwp[n] + 1;
  endtask

  task automatic wait_wr(input int n, input int budget,
                         input string tag);
    int k = 0;
    while (wlog.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(wlog.size() >= n), 64'd1);
  endtask

  task automatic wait_drop(input int n, input int budget,
                           input string tag);
    int k = 0;
    while (drops < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(drops >= n), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base2, t0, tl, rb, d0, own_p, idx;
    logic [63:0] ev;
    reset_ = 1'b0;
    bus.tx_mac_usedw = 13'd0;
    bus.tx_mac_full  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_wr", 64'(bus.tx_mac_wr), 64'd0);
    chk("rst_data", bus.tx_mac_data, 64'd0);
    chk("rst_drop", 64'(drop_pulse), 64'd0);
    chk("rst_cnt0", 64'(pkt_cnt0), 64'd0);
    chk("rst_cnt1", 64'(pkt_cnt1), 64'd0);
    chk("rst_rden", 64'({bus.r0_cnt_rden, bus.r1_cnt_rden,
                         bus.r0_dat_rden, bus.r1_dat_rden}),
        64'd0);
    reset_ = 1'b1;
    repeat (2) @(negedge clk);

    // both requesters, three 60-byte packets each
    base = wlog.size();
    for (int k = 0; k < 24; k++) begin
      push_d(0, 64'h1000 + 64'(k));
      push_d(1, 64'h2000 + 64'(k));
    end
    for (int k = 0; k < 3; k++) begin
      push_c(0, 16'd60);
      push_c(1, 16'd60);
    end
    wait_wr(base + 54, 500, "t2_timeout");
    for (int p = 0; p < 6; p++) begin
`ifdef ARB_STRICT_PRI_EN
      own_p = p / 3;
      idx   = p % 3;
`else
      own_p = p % 2;
      idx   = p / 2;
`endif
      ev = (own_p == 1) ? 64'h2000 : 64'h1000;
      chk("t2_owner", 64'(glog[base + 9 * p]),
          (own_p == 1) ? 64'd2 : 64'd1);
      chk("t2_hdr", wlog[base + 9 * p], 64'd60);
      chk("t2_first", wlog[base + 9 * p + 1],
          ev + 64'(8 * idx));
    end
    chk("t2_b2b", 64'(wcyc[base + 9] - wcyc[base + 8]), 64'd3);
    repeat (3) @(negedge clk);
    chk("t2_cnt0", 64'(pkt_cnt0), 64'd3);
    chk("t2_cnt1", 64'(pkt_cnt1), 64'd3);

    // single r0 packet, latency and ordering
    base = wlog.size();
    for (int k = 0; k < 8; k++) push_d(0, 64'hA0 + 64'(k));
    push_c(0, 16'd64);
    t0 = cyc;
    wait_wr(base + 9, 100, "t1_timeout");
    chk("t1_hdr", wlog[base], 64'h40);
    chk("t1_lat", 64'(wcyc[base] - t0), 64'd3);
    chk("t1_grant", 64'(glog[base]), 64'd1);
    for (int k = 0; k < 8; k++)
      chk("t1_dat", wlog[base + 1 + k], 64'hA0 + 64'(k));
    repeat (3) @(negedge clk);
    chk("t1_cnt0", 64'(pkt_cnt0), 64'd4);
    chk("t1_idle", 64'(grant), 64'd0);
    chk("t1_nodrop", 64'(drops), 64'd0);

    // oversize drop on r1, then zero-length drop on r0
    base = wlog.size();
    rb = drp[1];
    d0 = drops;
    for (int k = 0; k < 190; k++) push_d(1, 64'h3000 + 64'(k));
    push_c(1, 16'd1519);
    wait_drop(d0 + 1, 400, "t3_timeout");
    repeat (3) @(negedge clk);
    chk("t3_reads", 64'(drp[1] - rb), 64'd190);
    chk("t3_nowr", 64'(wlog.size() - base), 64'd0);
    chk("t3_drops", 64'(drops - d0), 64'd1);
    chk("t3_cnt1", 64'(pkt_cnt1), 64'd3);
    rb = drp[0];
    push_c(0, 16'd0);
    wait_drop(d0 + 2, 50, "t3z_timeout");
    repeat (3) @(negedge clk);
    chk("t3z_reads", 64'(drp[0] - rb), 64'd0);
    chk("t3z_drops", 64'(drops - d0), 64'd2);
    chk("t3z_nowr", 64'(wlog.size() - base), 64'd0);
    chk("t3z_cnt0", 64'(pkt_cnt0), 64'd4);

    // space reservation boundary
    bus.tx_mac_usedw = 13'd8180;
    base = wlog.size();
    for (int k = 0; k < 8; k++) push_d(0, 64'hC0 + 64'(k));
    push_c(0, 16'd64);
    repeat (15) @(negedge clk);
    chk("t4_stall", 64'(wlog.size() - base), 64'd0);
    chk("t4_grant", 64'(grant), 64'd1);
    bus.tx_mac_usedw = 13'd8179;
    tl = cyc;
    wait_wr(base + 9, 50, "t4_timeout");
    chk("t4_lat", 64'(wcyc[base] - tl), 64'd1);
    chk("t4_last", wlog[base + 8], 64'hC7);
    bus.tx_mac_usedw = 13'd0;

    // data FIFO runs dry mid-packet
    base = wlog.size();
    for (int k = 0; k < 3; k++) push_d(0, 64'hD0 + 64'(k));
    push_c(0, 16'd64);
    wait_wr(base + 4, 50, "t5_timeout_a");
    push_d(1, 64'hE0);
    push_c(1, 16'd8);
    repeat (20) @(negedge clk);
    chk("t5_gap", 64'(wlog.size() - base), 64'd4);
    chk("t5_grant", 64'(grant), 64'd1);
    for (int k = 3; k < 8; k++) push_d(0, 64'hD0 + 64'(k));
    wait_wr(base + 11, 100, "t5_timeout_b");
    chk("t5_last", wlog[base + 8], 64'hD7);
    chk("t5_r1grant", 64'(glog[base + 9]), 64'd2);
    chk("t5_r1hdr", wlog[base + 9], 64'd8);
    chk("t5_r1dat", wlog[base + 10], 64'hE0);
    repeat (3) @(negedge clk);
    chk("t5_cnt0", 64'(pkt_cnt0), 64'd6);
    chk("t5_cnt1", 64'(pkt_cnt1), 64'd4);

    // reset in the middle of a packet
    base = wlog.size();
    for (int k = 0; k < 8; k++) push_d(0, 64'hF0 + 64'(k));
    push_c(0, 16'd64);
    wait_wr(base + 3, 50, "t6_timeout_a");
    reset_ = 1'b0;
    #1;
    chk("t6_grant", 64'(grant), 64'd0);
    chk("t6_wr", 64'(bus.tx_mac_wr), 64'd0);
    chk("t6_cnt0", 64'(pkt_cnt0), 64'd0);
    chk("t6_cnt1", 64'(pkt_cnt1), 64'd0);
    chk("t6_rden", 64'(bus.r0_dat_rden), 64'd0);
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);
    base2 = wlog.size();
    push_d(1, 64'hBEEF0);
    push_d(1, 64'hBEEF1);
    push_c(1, 16'd16);
    wait_wr(base2 + 3, 50, "t6_timeout_b");
    chk("t6_r1grant", 64'(glog[base2]), 64'd2);
    chk("t6_r1hdr", wlog[base2], 64'd16);
    chk("t6_r1d0", wlog[base2 + 1], 64'hBEEF0);
    chk("t6_r1d1", wlog[base2 + 2], 64'hBEEF1);
    repeat (3) @(negedge clk);
    chk("t6_r1cnt", 64'(pkt_cnt1), 64'd1);
    chk("underflow", 64'(uflow), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
